// File: rtl/draw_sequencer.sv
// draw_sequencer: frame-draw controller between the game FSM, the background
// and sprite pixel engines, and the VGA adapter write port.
// Sequences background then sprite (or sprite only), re-times the engine pixel
// streams through a two-stage pipe and owns every VGA write signal.
// Optional build macro: DRAW_SEQ_TRANSPARENT_EN makes black sprite pixels
// transparent (never written). Without it every in-bounds pixel is written.

module draw_sequencer #(
   parameter int X_SCREEN_PIXELS = 160,
   parameter int Y_SCREEN_PIXELS = 120,
   parameter int DRAIN_CYCLES    = 2
) (
   input  logic       Clock,
   input  logic       Reset,
   input  logic       drawRequest,
   input  logic       spriteRequest,
   output logic       bgSignal,
   output logic       bgPlot,
   input  logic [7:0] bgX,
   input  logic [6:0] bgY,
   input  logic [2:0] bgColour,
   input  logic       bgDone,
   output logic       spSignal,
   output logic       spPlot,
   input  logic [7:0] spX,
   input  logic [6:0] spY,
   input  logic [2:0] spColour,
   input  logic       spDone,
   output logic [7:0] vgaX,
   output logic [6:0] vgaY,
   output logic [2:0] vgaColour,
   output logic       vgaWriteEn,
   output logic       busy,
   output logic       frameDone
);

   // A drain of fewer than one cycle is treated as one cycle.
   localparam int               CNT_W    = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = (DRAIN_CYCLES > 1) ? CNT_W'(DRAIN_CYCLES - 1)
                                                               : {CNT_W{1'b0}};
   // Limits widened by one bit so a full 256/128 screen still compares correctly.
   localparam logic [8:0]       X_LIM    = 9'(X_SCREEN_PIXELS);
   localparam logic [7:0]       Y_LIM    = 8'(Y_SCREEN_PIXELS);

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_BG_RUN   = 3'd1,
      ST_BG_DRAIN = 3'd2,
      ST_SP_RUN   = 3'd3,
      ST_SP_DRAIN = 3'd4,
      ST_FINISH   = 3'd5
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] drain_q, drain_d;
   logic             pend_full_q, pend_full_d;
   logic             pend_sp_q, pend_sp_d;

   logic             bg_strobe_q, sp_strobe_q, busy_q, frame_done_q;

   logic [7:0]       s1_x_q, s1_x_d;
   logic [6:0]       s1_y_q, s1_y_d;
   logic             s1_valid_q, s1_valid_d;
   logic             s1_sp_q, s1_sp_d;

   logic [7:0]       vga_x_q;
   logic [6:0]       vga_y_q;
   logic [2:0]       vga_colour_q, vga_colour_d;
   logic             vga_we_q, vga_we_d;
   logic             transparent_s;

   // Sequencing FSM: picks the next phase and counts the post-done drain.
   always_comb begin
      state_d = state_q;
      drain_d = {CNT_W{1'b0}};
      case (state_q)
         ST_IDLE: begin
            if (drawRequest || pend_full_q) begin
               state_d = ST_BG_RUN;
            end else if (spriteRequest || pend_sp_q) begin
               state_d = ST_SP_RUN;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_BG_RUN: begin
            if (bgDone) begin
               state_d = ST_BG_DRAIN;
            end else begin
               state_d = ST_BG_RUN;
            end
         end
         ST_BG_DRAIN: begin
            if (drain_q == CNT_LAST) begin
               state_d = ST_SP_RUN;
            end else begin
               drain_d = drain_q + CNT_W'(1'b1);
            end
         end
         ST_SP_RUN: begin
            if (spDone) begin
               state_d = ST_SP_DRAIN;
            end else begin
               state_d = ST_SP_RUN;
            end
         end
         ST_SP_DRAIN: begin
            if (drain_q == CNT_LAST) begin
               state_d = ST_FINISH;
            end else begin
               drain_d = drain_q + CNT_W'(1'b1);
            end
         end
         ST_FINISH: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // One-deep request memory: set while busy, cleared when the sequence starts.
   // A full redraw already includes the sprite, so it swallows a sprite request.
   always_comb begin
      pend_full_d = pend_full_q;
      pend_sp_d   = pend_sp_q;
      if (state_q != ST_IDLE) begin
         if (drawRequest) begin
            pend_full_d = 1'b1;
            pend_sp_d   = 1'b0;
         end else if (spriteRequest) begin
            pend_sp_d = 1'b1;
         end else begin
            pend_sp_d = pend_sp_q;
         end
      end else begin
         if (state_d == ST_BG_RUN) begin
            pend_full_d = 1'b0;
            pend_sp_d   = 1'b0;
         end else if (state_d == ST_SP_RUN) begin
            pend_sp_d = 1'b0;
         end else begin
            pend_sp_d = pend_sp_q;
         end
      end
   end

   // Stage-1 source mux: only the engine owned by the current run state is seen.
   always_comb begin
      s1_x_d     = bgX;
      s1_y_d     = bgY;
      s1_sp_d    = 1'b0;
      s1_valid_d = 1'b0;
      case (state_q)
         ST_BG_RUN: begin
            s1_valid_d = !bgDone;
         end
         ST_SP_RUN: begin
            s1_x_d     = spX;
            s1_y_d     = spY;
            s1_sp_d    = 1'b1;
            s1_valid_d = !spDone;
         end
         default: begin
            s1_valid_d = 1'b0;
         end
      endcase
   end

`ifdef DRAW_SEQ_TRANSPARENT_EN
   assign transparent_s = s1_sp_q && (vga_colour_d == 3'b000);
`else
   assign transparent_s = 1'b0;
`endif

   // Stage-2 colour pick (colour now lines up with stage-1 X/Y) and write gate.
   always_comb begin
      vga_colour_d = bgColour;
      if (s1_sp_q) begin
         vga_colour_d = spColour;
      end else begin
         vga_colour_d = bgColour;
      end
      vga_we_d = s1_valid_q
              && ({1'b0, s1_x_q} < X_LIM)
              && ({1'b0, s1_y_q} < Y_LIM)
              && !transparent_s;
   end

   // Control state, pending flags and strobes; strobes decode the next state.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q      <= ST_IDLE;
         drain_q      <= {CNT_W{1'b0}};
         pend_full_q  <= 1'b0;
         pend_sp_q    <= 1'b0;
         bg_strobe_q  <= 1'b0;
         sp_strobe_q  <= 1'b0;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         drain_q      <= drain_d;
         pend_full_q  <= pend_full_d;
         pend_sp_q    <= pend_sp_d;
         bg_strobe_q  <= (state_d == ST_BG_RUN);
         sp_strobe_q  <= (state_d == ST_SP_RUN);
         busy_q       <= (state_d != ST_IDLE);
         frame_done_q <= (state_d == ST_FINISH);
      end
   end

   // Two-stage pixel pipe feeding the VGA write port.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         s1_x_q       <= 8'd0;
         s1_y_q       <= 7'd0;
         s1_valid_q   <= 1'b0;
         s1_sp_q      <= 1'b0;
         vga_x_q      <= 8'd0;
         vga_y_q      <= 7'd0;
         vga_colour_q <= 3'd0;
         vga_we_q     <= 1'b0;
      end else begin
         s1_x_q       <= s1_x_d;
         s1_y_q       <= s1_y_d;
         s1_valid_q   <= s1_valid_d;
         s1_sp_q      <= s1_sp_d;
         vga_x_q      <= s1_x_q;
         vga_y_q      <= s1_y_q;
         vga_colour_q <= vga_colour_d;
         vga_we_q     <= vga_we_d;
      end
   end

   assign bgSignal   = bg_strobe_q;
   assign bgPlot     = bg_strobe_q;
   assign spSignal   = sp_strobe_q;
   assign spPlot     = sp_strobe_q;
   assign busy       = busy_q;
   assign frameDone  = frame_done_q;
   assign vgaX       = vga_x_q;
   assign vgaY       = vga_y_q;
   assign vgaColour  = vga_colour_q;
   assign vgaWriteEn = vga_we_q;

endmodule

// File: tb/tb_draw_sequencer.sv
// tb_draw_sequencer: self-checking bench for draw_sequencer with behavioural
// 160x120 background and 8x8 sprite engines.

module tb_draw_sequencer;

   logic       Clock, Reset, drawRequest, spriteRequest;
   logic       bgSignal, bgPlot, bgDone, spSignal, spPlot, spDone;
   logic [7:0] bgX, spX, vgaX;
   logic [6:0] bgY, spY, vgaY;
   logic [2:0] bgColour, spColour, vgaColour;
   logic       vgaWriteEn, busy, frameDone;

   draw_sequencer dut (
      .Clock(Clock), .Reset(Reset),
      .drawRequest(drawRequest), .spriteRequest(spriteRequest),
      .bgSignal(bgSignal), .bgPlot(bgPlot), .bgX(bgX), .bgY(bgY),
      .bgColour(bgColour), .bgDone(bgDone),
      .spSignal(spSignal), .spPlot(spPlot), .spX(spX), .spY(spY),
      .spColour(spColour), .spDone(spDone),
      .vgaX(vgaX), .vgaY(vgaY), .vgaColour(vgaColour), .vgaWriteEn(vgaWriteEn),
      .busy(busy), .frameDone(frameDone)
   );

`ifdef DRAW_SEQ_TRANSPARENT_EN
   localparam int EXP_BLACK_SP = 48;
`else
   localparam int EXP_BLACK_SP = 65;
`endif

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   // ---------------- engine models ----------------
   logic [7:0] sp_x0;
   logic [6:0] sp_y0;
   logic       sp_black, force_bg_done;

   logic [7:0] bcx;
   logic [6:0] bcy;
   logic       bstart, bdone;
   logic [2:0] bcol;
   logic [2:0] scx, scy;
   logic       sstart, sdone;
   logic [2:0] scol;

   function automatic logic [2:0] bg_rom(input logic [7:0] x, input logic [6:0] y);
      logic [7:0] s;
      s = x + {1'b0, y};
      return s[2:0];
   endfunction

   // black pattern: (cx+cy)%4==0 -> 16 of 64 pixels, origin included
   function automatic logic [2:0] sp_rom(input logic [2:0] cx, input logic [2:0] cy, input logic blk);
      logic [3:0] s;
      s = {1'b0, cx} + {1'b0, cy};
      if (blk) return (s[1:0] == 2'd0) ? 3'd0 : 3'd2;
      return 3'(s % 4'd7) + 3'd1;
   endfunction

   // Background engine: held at (0,0) while plot low, repeats (0,0) once, raster scan.
   always @(posedge Clock) begin
      bcol <= bg_rom(bcx, bcy);
      if (!bgPlot) begin
         bcx <= 8'd0; bcy <= 7'd0; bstart <= 1'b0; bdone <= 1'b0;
      end else if (!bstart) begin
         bstart <= 1'b1;
      end else if (!bdone) begin
         if (bcx == 8'd159 && bcy == 7'd119) bdone <= 1'b1;
         else if (bcx == 8'd159) begin bcx <= 8'd0; bcy <= bcy + 7'd1; end
         else bcx <= bcx + 8'd1;
      end
   end

   // Sprite engine: same contract, 8x8 at (sp_x0, sp_y0).
   always @(posedge Clock) begin
      scol <= sp_rom(scx, scy, sp_black);
      if (!spPlot) begin
         scx <= 3'd0; scy <= 3'd0; sstart <= 1'b0; sdone <= 1'b0;
      end else if (!sstart) begin
         sstart <= 1'b1;
      end else if (!sdone) begin
         if (scx == 3'd7 && scy == 3'd7) sdone <= 1'b1;
         else if (scx == 3'd7) begin scx <= 3'd0; scy <= scy + 3'd1; end
         else scx <= scx + 3'd1;
      end
   end

   assign bgX = bcx;  assign bgY = bcy;  assign bgColour = bcol;
   assign bgDone = bdone | force_bg_done;
   assign spX = sp_x0 + {5'd0, scx};
   assign spY = sp_y0 + {4'd0, scy};
   assign spColour = scol;  assign spDone = sdone;

   // ---------------- monitor ----------------
   int  bg_writes, sp_writes, frames, oob, sp_stray, both_on;
   int  bg_fx[2], bg_fy[2];
   int  bg_lx, bg_ly, bg_lc;
   logic sp_hist0, sp_hist1;

   // A write leaving the pipe now came from the engine active two cycles ago.
   always @(negedge Clock) begin
      if (bgPlot && spPlot) both_on++;
      if (frameDone) frames++;
      if (vgaWriteEn) begin
         if (vgaX >= 8'd160 || vgaY >= 7'd120) oob++;
         if (sp_hist1) begin
            sp_writes++;
            if (vgaX < sp_x0 || vgaX > sp_x0 + 8'd7 || vgaY < sp_y0 || vgaY > sp_y0 + 7'd7) sp_stray++;
         end else begin
            if (bg_writes < 2) begin bg_fx[bg_writes] = vgaX; bg_fy[bg_writes] = vgaY; end
            bg_lx = vgaX; bg_ly = vgaY; bg_lc = vgaColour;
            bg_writes++;
         end
      end
      sp_hist1 = sp_hist0;
      sp_hist0 = spPlot;
   end

   // ---------------- checking helpers ----------------
   int n_cmp, n_fail;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: actual %0d required %0d", name, act, exp);
      end
   endtask

   task automatic clear_counters();
      bg_writes = 0; sp_writes = 0; frames = 0; oob = 0; sp_stray = 0; both_on = 0;
      bg_fx[0] = -1; bg_fy[0] = -1; bg_fx[1] = -1; bg_fy[1] = -1;
      bg_lx = -1; bg_ly = -1; bg_lc = -1;
   endtask

   task automatic pulse(input logic d, input logic s);
      @(posedge Clock); #1;
      drawRequest = d; spriteRequest = s;
      @(posedge Clock); #1;
      drawRequest = 1'b0; spriteRequest = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int streak, n;
      streak = 0; n = 0;
      while (streak < 4 && n < 30000) begin
         @(negedge Clock);
         n++;
         if (!busy) streak++; else streak = 0;
      end
      check(name, (streak >= 4) ? 1 : 0, 1);
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic       draw;
      logic       sprite;
      logic [7:0] sx;
      logic [6:0] sy;
      logic       black;
      logic       force_done;
      int         extra_sp;
      int         exp_bg;
      int         exp_sp;
      int         exp_frames;
   } row_t;

   row_t rows[6];

   initial begin
      // full frame; corner sprite (8 distinct + repeated origin = 9);
      // simultaneous requests; two sprite requests during BG_RUN;
      // sprite-only with 16 black pixels; bgDone already high on entry
      rows[0] = '{1'b1, 1'b0, 8'd10,  7'd20,  1'b0, 1'b0, 0, 19201, 65,  1};
      rows[1] = '{1'b0, 1'b1, 8'd156, 7'd118, 1'b0, 1'b0, 0, 0,     9,   1};
      rows[2] = '{1'b1, 1'b1, 8'd10,  7'd20,  1'b0, 1'b0, 0, 19201, 65,  1};
      rows[3] = '{1'b1, 1'b0, 8'd10,  7'd20,  1'b0, 1'b0, 2, 19201, 130, 2};
      rows[4] = '{1'b0, 1'b1, 8'd10,  7'd20,  1'b1, 1'b0, 0, 0, EXP_BLACK_SP, 1};
      rows[5] = '{1'b1, 1'b0, 8'd10,  7'd20,  1'b0, 1'b1, 0, 0,     65,  1};

      n_cmp = 0; n_fail = 0;
      drawRequest = 1'b0; spriteRequest = 1'b0;
      sp_x0 = 8'd10; sp_y0 = 7'd20; sp_black = 1'b0; force_bg_done = 1'b0;
      sp_hist0 = 1'b0; sp_hist1 = 1'b0;
      clear_counters();

      // ---- reset values ----
      Reset = 1'b1;
      repeat (3) @(posedge Clock);
      #1;
      check("rst_busy", busy, 0);
      check("rst_bgPlot", bgPlot, 0);
      check("rst_bgSignal", bgSignal, 0);
      check("rst_spPlot", spPlot, 0);
      check("rst_spSignal", spSignal, 0);
      check("rst_frameDone", frameDone, 0);
      check("rst_vgaWriteEn", vgaWriteEn, 0);
      check("rst_vgaXYC", {vgaX, vgaY, vgaColour}, 0);
      Reset = 1'b0;
      repeat (2) @(posedge Clock);

      // ---- request latency, then reset midway through BG_RUN ----
      @(posedge Clock); #1;
      drawRequest = 1'b1;
      @(posedge Clock); #1;
      drawRequest = 1'b0;
      check("req_busy", busy, 1);
      check("req_bgSignal", bgSignal, 1);
      check("req_bgPlot", bgPlot, 1);
      check("req_spPlot", spPlot, 0);
      repeat (300) @(posedge Clock);
      #1;
      check("mid_streaming", vgaWriteEn, 1);
      Reset = 1'b1;
      @(posedge Clock); #1;
      Reset = 1'b0;
      check("mid_rst_we", vgaWriteEn, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_bgPlot", bgPlot, 0);
      clear_counters();
      repeat (20) @(posedge Clock);
      check("mid_rst_no_frame", frames, 0);
      check("mid_rst_no_write", bg_writes + sp_writes, 0);
      pulse(1'b1, 1'b0);
      repeat (10) @(posedge Clock);
      #1;
      check("restart_seen", (bg_writes > 0) ? 1 : 0, 1);
      check("restart_x0", bg_fx[0], 0);
      check("restart_y0", bg_fy[0], 0);
      Reset = 1'b1;
      repeat (2) @(posedge Clock);
      #1;
      Reset = 1'b0;
      repeat (4) @(posedge Clock);

      // ---- table-driven sequences ----
      for (int i = 0; i < 6; i++) begin
         sp_x0 = rows[i].sx; sp_y0 = rows[i].sy;
         sp_black = rows[i].black; force_bg_done = rows[i].force_done;
         clear_counters();
         pulse(rows[i].draw, rows[i].sprite);
         for (int k = 0; k < rows[i].extra_sp; k++) begin
            repeat (100) @(posedge Clock);
            pulse(1'b0, 1'b1);
         end
         wait_idle($sformatf("row%0d_idle_timeout", i));
         check($sformatf("row%0d_bg_writes", i), bg_writes, rows[i].exp_bg);
         check($sformatf("row%0d_sp_writes", i), sp_writes, rows[i].exp_sp);
         check($sformatf("row%0d_frames", i), frames, rows[i].exp_frames);
         check($sformatf("row%0d_oob", i), oob, 0);
         check($sformatf("row%0d_sp_stray", i), sp_stray, 0);
         check($sformatf("row%0d_both_on", i), both_on, 0);
         if (rows[i].exp_bg > 0) begin
            check($sformatf("row%0d_bg_first0", i), bg_fx[0] * 1000 + bg_fy[0], 0);
            check($sformatf("row%0d_bg_first1", i), bg_fx[1] * 1000 + bg_fy[1], 0);
            check($sformatf("row%0d_bg_last_x", i), bg_lx, 159);
            check($sformatf("row%0d_bg_last_y", i), bg_ly, 119);
            check($sformatf("row%0d_bg_last_col", i), bg_lc, 6);
         end
         force_bg_done = 1'b0;
         repeat (2) @(posedge Clock);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/draw_sequencer.md
# draw_sequencer

Frame-draw controller on the consumer side of the pixel-engine interface. It starts the background engine and the sprite engine in order, re-times their pixel streams, and drives the VGA adapter write port. It is the sole owner of the VGA `x`/`y`/`colour`/`writeEn` signals. It also gives the game FSM a request/complete handshake for full-frame and sprite-only redraws.

## Interface
Parameters:
- `X_SCREEN_PIXELS`, default 160: visible width; pixels with x ≥ this value are never written.
- `Y_SCREEN_PIXELS`, default 120: visible height; pixels with y ≥ this value are never written.
- `DRAIN_CYCLES`, default 2: pipeline flush length after an engine reports done.

Ports:
- `Clock` in 1: single clock.
- `Reset` in 1: synchronous, active-high.
- `drawRequest` in 1: one-cycle pulse; redraw background, then sprite.
- `spriteRequest` in 1: one-cycle pulse; redraw sprite only.
- `bgSignal` out 1: start/run strobe to the background engine.
- `bgPlot` out 1: enable to the background engine; low holds its counters and done in reset.
- `bgX` in 8, `bgY` in 7: background engine coordinates.
- `bgColour` in 3: background colour; lags `bgX`/`bgY` by 1 cycle.
- `bgDone` in 1: background engine finished (level).
- `spSignal` out 1, `spPlot` out 1: same contract as `bgSignal`/`bgPlot`, for the sprite engine.
- `spX` in 8, `spY` in 7, `spColour` in 3, `spDone` in 1: sprite engine stream, same 1-cycle colour lag.
- `vgaX` out 8, `vgaY` out 7, `vgaColour` out 3, `vgaWriteEn` out 1: VGA adapter write port, all registered.
- `busy` out 1: high in any state except IDLE.
- `frameDone` out 1: one-cycle pulse when a sequence completes.

## Operation
- FSM states: IDLE, BG_RUN, BG_DRAIN, SP_RUN, SP_DRAIN, FINISH.
- IDLE:
  - `drawRequest` or pending-full → BG_RUN.
  - Otherwise `spriteRequest` or pending-sprite → SP_RUN.
  - Full wins on simultaneous requests and clears pending-sprite.
- BG_RUN: `bgSignal`=`bgPlot`=1. On `bgDone`=1 → BG_DRAIN.
- BG_DRAIN: both background strobes 0, which resets the engine. After `DRAIN_CYCLES` cycles → SP_RUN.
- SP_RUN and SP_DRAIN: same behaviour using the `sp*` signals. SP_DRAIN then → FINISH.
- FINISH: `frameDone`=1 for one cycle → IDLE.
- Pending flags, one-deep each:
  - A request arriving while `busy` sets its flag. A repeated request does not stack.
  - A flag clears when its sequence is entered.
  - `drawRequest` while busy also clears pending-sprite.
- Pixel pipeline:
  - Stage 1 registers the active engine's X/Y and a valid bit. Valid = (state is *_RUN) && !done.
  - Stage 2 registers stage-1 X/Y, the engine colour (now aligned), and valid into the `vga*` outputs.
  - `vgaWriteEn` = stage-1 valid && x < `X_SCREEN_PIXELS` && y < `Y_SCREEN_PIXELS`.
- Source mux selects on the current state; the inactive engine's inputs are ignored.

## Timing
- Reset values:
  - State IDLE; both pending flags 0.
  - All strobes 0, `busy` 0, `frameDone` 0.
  - `vgaX`/`vgaY`/`vgaColour` 0, `vgaWriteEn` 0; stage-1 valid 0.
- Latency: an engine coordinate presented in cycle n appears on `vga*` after the edge ending cycle n+1.
- Request pulse at edge k: `busy` and the engine strobes are high from edge k+1.
- The engine's first cycle repeats coordinate (0,0), so a full background produces X·Y+1 writes (19201 at defaults).
- The done cycle itself is not valid. The last valid pixel leaves the pipe within `DRAIN_CYCLES`, so no write is lost or crosses into the next engine's stream.
- Reset mid-sequence: at the next edge `vgaWriteEn`=0, strobes are 0, and the state is IDLE. No `frameDone` is produced.
- `bgDone` already high on entry to BG_RUN: zero valid pixels, go straight to drain.

## Configuration
- `DRAW_SEQ_TRANSPARENT_EN`:
  - Defined: sprite pixels with colour 3'b000 are transparent. `vgaWriteEn` is forced to 0 for them; background pixels are unaffected.
  - Undefined: every in-bounds sprite pixel is written, including black.

## Test plan
- Reset, then `drawRequest` with a model 160×120 background engine and an 8×8 sprite engine at (10,20) → 19201 background writes (first two at (0,0)), then 65 sprite writes. Last background write is (159,119) with the ROM colour. `frameDone` pulses once.
- Sprite at (156,118), 8×8 → only 4×2=8 in-bounds pixels written; no write with x ≥ 160 or y ≥ 120.
- `drawRequest` and `spriteRequest` in the same cycle → one full sequence, one `frameDone`, no extra sprite pass.
- `spriteRequest` twice during BG_RUN → after the current frame, exactly one sprite-only pass and two `frameDone` pulses in total.
- `Reset` asserted midway through BG_RUN → next cycle `vgaWriteEn`=0, `busy`=0, `bgPlot`=0; a subsequent `drawRequest` restarts at (0,0).
- With `DRAW_SEQ_TRANSPARENT_EN` defined, a sprite with 3'b000 in 16 of 64 pixels → 48 sprite writes. Without the macro → 65.
